// File: rtl/i2s_tx_master.sv
// I2S master transmitter: 16-bit stereo PCM, Philips format, 32 BCLK per frame.
// A single-frame holding register is filled over valid/ready and copied into
// the 32-bit shifter at each frame boundary.
module i2s_tx_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        en,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i2s_bclk,
  output logic        i2s_ws,
  output logic        i2s_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [4:0]    POS_LAST = 5'd31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic [4:0]    pos_q, pos_d;
  logic [31:0]   shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic [15:0]   hold_l_q, hold_l_d;
  logic [15:0]   hold_r_q, hold_r_d;
  logic          frame_start_q, frame_start_d;
  logic          underrun_q, underrun_d;

  logic tick;
  logic accept;

  assign tick   = (div_cnt_q == DIV_MAX);
  assign accept = in_valid & ~hold_full_q;

  // State register: every piece of sequential state, cleared by RESET.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      pos_q         <= POS_LAST;
      shift_q       <= '0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      pos_q         <= pos_d;
      shift_q       <= shift_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Next state: handshake, BCLK divider, slot counter, shifter and frame load/stop.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bclk_d        = bclk_q;
    pos_d         = pos_q;
    shift_d       = shift_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    // Holding register fill; active in both states so it can be prefilled.
    // A load needs the register full and an accept needs it empty, so the
    // load below never collides with this.
    if (accept) begin
      hold_l_d    = in_l;
      hold_r_d    = in_r;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        pos_d     = POS_LAST;
        shift_d   = '0;
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q + DW'(1);
        end else begin
          div_cnt_d = '0;
          if (!bclk_q) begin
            // Rise event: the peer samples here; nothing else moves.
            bclk_d = 1'b1;
          end else begin
            // Fall event: BCLK low, slot/shift/WS/DATA advance together.
            bclk_d = 1'b0;
            if (pos_q == POS_LAST) begin
              if (en) begin
                pos_d         = '0;
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                  shift_d     = {hold_l_q, hold_r_q};
                  hold_full_d = 1'b0;
                end else begin
                  shift_d    = '0;
                  underrun_d = 1'b1;
                end
              end else begin
                // Stop only at the frame boundary; the holding register is kept.
                state_d   = ST_IDLE;
                pos_d     = POS_LAST;
                shift_d   = '0;
              end
            end else begin
              pos_d   = pos_q + 5'd1;
              shift_d = {shift_q[30:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // WS is decoded from the slot position so it leads each word by one BCLK.
  assign i2s_ws      = (pos_q >= 5'd15) && (pos_q <= 5'd30);
  assign i2s_data    = shift_q[31];
  assign i2s_bclk    = bclk_q;
  assign in_ready    = ~hold_full_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: one DUT with CLK_DIV=4, one with CLK_DIV=1.
module tb_i2s_tx_master;

  localparam int LIM = 2000;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        en_a, en_b, valid_a, valid_b;
  logic [15:0] l_a, r_a, l_b, r_b;
  logic        rdy_a, bclk_a, ws_a, data_a, fs_a, ur_a;
  logic        rdy_b, bclk_b, ws_b, data_b, fs_b, ur_b;

  logic sel;
  logic m_bclk, m_ws, m_data, m_fs, m_ready;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc;
  int fs_cnt, ur_cnt, co_cnt;

  always #5 clk_sys = ~clk_sys;

  i2s_tx_master #(.CLK_DIV(4)) u_dut_a (
    .clk_sys(clk_sys), .RESET(rst), .en(en_a),
    .in_l(l_a), .in_r(r_a), .in_valid(valid_a), .in_ready(rdy_a),
    .i2s_bclk(bclk_a), .i2s_ws(ws_a), .i2s_data(data_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  i2s_tx_master #(.CLK_DIV(1)) u_dut_b (
    .clk_sys(clk_sys), .RESET(rst), .en(en_b),
    .in_l(l_b), .in_r(r_b), .in_valid(valid_b), .in_ready(rdy_b),
    .i2s_bclk(bclk_b), .i2s_ws(ws_b), .i2s_data(data_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  assign m_bclk  = sel ? bclk_b : bclk_a;
  assign m_ws    = sel ? ws_b   : ws_a;
  assign m_data  = sel ? data_b : data_a;
  assign m_fs    = sel ? fs_b   : fs_a;
  assign m_ready = sel ? rdy_b  : rdy_a;

  // Free-running cycle count for period measurement.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Pulse counters for DUT A, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (fs_a === 1'b1) fs_cnt <= fs_cnt + 1;
    if (ur_a === 1'b1) ur_cnt <= ur_cnt + 1;
    if (fs_a === 1'b1 && ur_a === 1'b1) co_cnt <= co_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_fs(input string tag);
    int g;
    g = 0;
    while (m_fs !== 1'b1 && g < LIM) begin
      tick();
      g++;
    end
    chk({tag, "_fs_timeout"}, 32'(g >= LIM), 32'd0);
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    int   g;
    prev = m_bclk;
    tick();
    g = 0;
    while (!(prev === 1'b0 && m_bclk === 1'b1) && g < 200) begin
      prev = m_bclk;
      tick();
      g++;
    end
    chk({tag, "_rise_timeout"}, 32'(g >= 200), 32'd0);
  endtask

  // Receive one frame: wait for its load, then sample DATA/WS on 32 rises.
  task automatic recv_frame(input string tag, output logic [15:0] l, output logic [15:0] r,
                            output logic ws_ok, output int period, output logic rdy_at_fs);
    logic [31:0] sh;
    int t0;
    wait_fs(tag);
    rdy_at_fs = m_ready;
    sh = '0;
    ws_ok = 1'b1;
    period = 0;
    t0 = 0;
    for (int k = 0; k < 32; k++) begin
      wait_rise(tag);
      if (k == 0) t0 = cyc;
      if (k == 1) period = cyc - t0;
      sh = {sh[30:0], m_data};
      if (m_ws !== ((k >= 15 && k <= 30) ? 1'b1 : 1'b0)) ws_ok = 1'b0;
    end
    l = sh[31:16];
    r = sh[15:0];
    $display("frame %s: L=%h R=%h ws_ok=%0d period=%0d", tag, l, r, ws_ok, period);
  endtask

  // Present a sample pair on DUT A, wait for ready, complete the accept.
  task automatic push_a(input string tag, input logic [15:0] l, input logic [15:0] r);
    int g;
    l_a = l;
    r_a = r;
    valid_a = 1'b1;
    g = 0;
    while (rdy_a !== 1'b1 && g < LIM) begin
      tick();
      g++;
    end
    chk({tag, "_ready_timeout"}, 32'(g >= LIM), 32'd0);
    tick();
    chk({tag, "_ready_low_after_accept"}, 32'(rdy_a), 32'd0);
    $display("push %s: L=%h R=%h", tag, l, r);
  endtask

  initial begin
    logic [15:0] rl, rr;
    logic        wok, rfs;
    int          per, s_fs, s_ur, s_co, rises, nt;
    logic        prev;
    logic [15:0] exp_l [3];
    logic [15:0] exp_r [3];
    exp_l[0] = 16'h1234; exp_r[0] = 16'h5678;
    exp_l[1] = 16'h8000; exp_r[1] = 16'h7FFF;
    exp_l[2] = 16'hFFFF; exp_r[2] = 16'h0001;

    sel = 1'b0;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    l_a = '0; r_a = '0; l_b = '0; r_b = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_bclk", 32'(bclk_a), 32'd0);
    chk("rst_ws", 32'(ws_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_fs", 32'(fs_a), 32'd0);
    chk("rst_ur", 32'(ur_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    rst = 1'b0;
    tick();

    // Prefill in IDLE, then run: first frame carries the prefilled pair
    push_a("prefill", 16'hA5F0, 16'h0FF1);
    valid_a = 1'b0;
    en_a = 1'b1;
    s_ur = ur_cnt;
    recv_frame("first", rl, rr, wok, per, rfs);
    chk("first_L", 32'(rl), 32'hA5F0);
    chk("first_R", 32'(rr), 32'h0FF1);
    chk("first_ws", 32'(wok), 32'd1);
    chk("first_period", 32'(per), 32'd8);
    chk("first_ready_at_fs", 32'(rfs), 32'd1);
    chk("first_no_underrun", 32'(ur_cnt - s_ur), 32'd0);

    // No new input: next frame is zeros with one underrun on frame_start
    s_fs = fs_cnt; s_ur = ur_cnt; s_co = co_cnt;
    recv_frame("underrun", rl, rr, wok, per, rfs);
    chk("ur_L", 32'(rl), 32'h0);
    chk("ur_R", 32'(rr), 32'h0);
    chk("ur_fs_count", 32'(fs_cnt - s_fs), 32'd1);
    chk("ur_count", 32'(ur_cnt - s_ur), 32'd1);
    chk("ur_coincident", 32'(co_cnt - s_co), 32'd1);

    // Three frames back-to-back with in_valid held high
    s_fs = fs_cnt; s_ur = ur_cnt;
    fork
      begin
        for (int i = 0; i < 3; i++) push_a("b2b", exp_l[i], exp_r[i]);
        valid_a = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) begin
          recv_frame("b2b", rl, rr, wok, per, rfs);
          chk("b2b_L", 32'(rl), 32'(exp_l[j]));
          chk("b2b_R", 32'(rr), 32'(exp_r[j]));
        end
      end
    join
    chk("b2b_fs_count", 32'(fs_cnt - s_fs), 32'd3);
    chk("b2b_no_underrun", 32'(ur_cnt - s_ur), 32'd0);

    // Stop mid-frame: the frame runs to pos 31, then everything idles low
    push_a("stopframe", 16'hFFFF, 16'hFFFF);
    valid_a = 1'b0;
    wait_fs("stop");
    push_a("kept", 16'hCAFE, 16'hBEEF);
    valid_a = 1'b0;
    for (int k = 0; k < 6; k++) wait_rise("to_pos5");
    en_a = 1'b0;
    s_fs = fs_cnt;
    rises = 0;
    prev = bclk_a;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (prev === 1'b0 && bclk_a === 1'b1) rises++;
      prev = bclk_a;
    end
    $display("stop: rises after drop=%0d", rises);
    chk("stop_rises", 32'(rises), 32'd26);
    chk("stop_no_fs", 32'(fs_cnt - s_fs), 32'd0);
    chk("stop_bclk", 32'(bclk_a), 32'd0);
    chk("stop_ws", 32'(ws_a), 32'd0);
    chk("stop_data", 32'(data_a), 32'd0);
    chk("stop_hold_kept", 32'(rdy_a), 32'd0);

    // Restart: held pair goes out first
    en_a = 1'b1;
    s_ur = ur_cnt;
    recv_frame("restart", rl, rr, wok, per, rfs);
    chk("restart_L", 32'(rl), 32'hCAFE);
    chk("restart_R", 32'(rr), 32'hBEEF);
    chk("restart_no_underrun", 32'(ur_cnt - s_ur), 32'd0);

    // Reset at pos 20 with the holding register full
    wait_fs("pre_reset");
    push_a("pre_reset", 16'h1111, 16'h2222);
    valid_a = 1'b0;
    for (int k = 0; k < 21; k++) wait_rise("to_pos20");
    chk("pos20_ws", 32'(ws_a), 32'd1);
    rst = 1'b1;
    en_a = 1'b0;
    tick();
    chk("midrst_bclk", 32'(bclk_a), 32'd0);
    chk("midrst_ws", 32'(ws_a), 32'd0);
    chk("midrst_data", 32'(data_a), 32'd0);
    chk("midrst_fs", 32'(fs_a), 32'd0);
    chk("midrst_ur", 32'(ur_a), 32'd0);
    chk("midrst_ready", 32'(rdy_a), 32'd1);
    rst = 1'b0;
    tick();
    en_a = 1'b1;
    s_ur = ur_cnt;
    recv_frame("after_reset", rl, rr, wok, per, rfs);
    chk("after_reset_L", 32'(rl), 32'h0);
    chk("after_reset_R", 32'(rr), 32'h0);
    chk("after_reset_underrun", 32'(ur_cnt - s_ur), 32'd1);
    en_a = 1'b0;

    // CLK_DIV=1: BCLK toggles every cycle, loopback recovers both samples
    sel = 1'b1;
    l_b = 16'h8001; r_b = 16'h7FFE; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    en_b = 1'b1;
    recv_frame("div1", rl, rr, wok, per, rfs);
    chk("div1_L", 32'(rl), 32'h8001);
    chk("div1_R", 32'(rr), 32'h7FFE);
    chk("div1_ws", 32'(wok), 32'd1);
    chk("div1_period", 32'(per), 32'd2);
    nt = 0;
    prev = bclk_b;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bclk_b === prev) nt++;
      prev = bclk_b;
    end
    chk("div1_toggle", 32'(nt), 32'd0);
    en_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
